// File: rtl/conv_engine_pkg.sv
// Shared types and helpers for the multichannel convolution engine:
// FSM state encoding, counter-width helper and the output saturate/ReLU stage.
package conv_engine_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    OUTPUT,
    DONE
  } state_e;

  // Widest intermediate the saturation stage handles; accumulators must fit in it.
  localparam int SAT_WIDTH = 64;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [SAT_WIDTH-1:0] sat_relu(
    input logic signed [SAT_WIDTH-1:0] v,
    input int                          dw,
    input logic                        relu
  );
    logic signed [SAT_WIDTH-1:0] one;
    logic signed [SAT_WIDTH-1:0] max_v;
    logic signed [SAT_WIDTH-1:0] min_v;
    logic signed [SAT_WIDTH-1:0] r;
    one   = 1;
    max_v = (one <<< (dw - 1)) - one;
    min_v = -(one <<< (dw - 1));
    if (v > max_v)      r = max_v;
    else if (v < min_v) r = min_v;
    else                r = v;
    if (relu && (r < 0)) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Tap and pixel counters for the convolution sweep plus the flattened
// feature-map / weight address computations derived from them.
module conv_addr_gen
  import conv_engine_pkg::*;
#(
  parameter int IN_WIDTH    = 12,
  parameter int IN_HEIGHT   = 12,
  parameter int KERNEL_SIZE = 3,
  parameter int CHANNEL_NUM = 4,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  step_tap_i,
  input  logic                  step_pixel_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic [ADDR_WIDTH-1:0] kernel_addr_o,
  output logic [ADDR_WIDTH-1:0] channel_o,
  output logic [ADDR_WIDTH-1:0] out_idx_o,
  output logic                  first_tap_o,
  output logic                  last_tap_o,
  output logic                  last_pixel_o
);

  localparam int OUT_W = IN_WIDTH - KERNEL_SIZE + 1;
  localparam int OUT_H = IN_HEIGHT - KERNEL_SIZE + 1;
  localparam int CW    = cnt_width(CHANNEL_NUM);
  localparam int KW    = cnt_width(KERNEL_SIZE);
  localparam int XW    = cnt_width(OUT_W);
  localparam int YW    = cnt_width(OUT_H);

  logic [CW-1:0] chan_q, chan_d;
  logic [KW-1:0] kr_q, kr_d, kc_q, kc_d;
  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;

  logic last_chan, last_kr, last_kc, last_col, last_row;

  assign last_chan = (chan_q == CW'(CHANNEL_NUM - 1));
  assign last_kr   = (kr_q == KW'(KERNEL_SIZE - 1));
  assign last_kc   = (kc_q == KW'(KERNEL_SIZE - 1));
  assign last_col  = (col_q == XW'(OUT_W - 1));
  assign last_row  = (row_q == YW'(OUT_H - 1));

  // Loop nest: channel outermost, then kernel row, kernel column innermost.
  always_comb begin
    chan_d = chan_q;
    kr_d   = kr_q;
    kc_d   = kc_q;
    col_d  = col_q;
    row_d  = row_q;
    if (clear_i) begin
      chan_d = '0;
      kr_d   = '0;
      kc_d   = '0;
      col_d  = '0;
      row_d  = '0;
    end else if (step_pixel_i) begin
      chan_d = '0;
      kr_d   = '0;
      kc_d   = '0;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + YW'(1);
      end else begin
        col_d = col_q + XW'(1);
      end
    end else if (step_tap_i) begin
      if (!last_kc) begin
        kc_d = kc_q + KW'(1);
      end else begin
        kc_d = '0;
        if (!last_kr) begin
          kr_d = kr_q + KW'(1);
        end else begin
          kr_d   = '0;
          chan_d = last_chan ? '0 : chan_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chan_q <= '0;
      kr_q   <= '0;
      kc_q   <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      chan_q <= chan_d;
      kr_q   <= kr_d;
      kc_q   <= kc_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

  assign kernel_addr_o = ADDR_WIDTH'(chan_q) * ADDR_WIDTH'(KERNEL_SIZE * KERNEL_SIZE)
                       + ADDR_WIDTH'(kr_q) * ADDR_WIDTH'(KERNEL_SIZE)
                       + ADDR_WIDTH'(kc_q);
  assign data_addr_o   = ADDR_WIDTH'(chan_q) * ADDR_WIDTH'(IN_WIDTH * IN_HEIGHT)
                       + (ADDR_WIDTH'(row_q) + ADDR_WIDTH'(kr_q)) * ADDR_WIDTH'(IN_WIDTH)
                       + (ADDR_WIDTH'(col_q) + ADDR_WIDTH'(kc_q));
  assign out_idx_o     = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(OUT_W) + ADDR_WIDTH'(col_q);
  assign channel_o     = ADDR_WIDTH'(chan_q);
  assign first_tap_o   = (chan_q == '0) && (kr_q == '0) && (kc_q == '0);
  assign last_tap_o    = last_chan && last_kr && last_kc;
  assign last_pixel_o  = last_row && last_col;

endmodule

// File: rtl/conv_multichannel_engine.sv
// Multichannel KxK valid-padding convolution: sequences taps, accumulates across
// all channels, adds bias, rescales, saturates and writes one result per pixel.
module conv_multichannel_engine
  import conv_engine_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int FRACTION_WIDTH = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int IN_WIDTH       = 12,
  parameter int IN_HEIGHT      = 12,
  parameter int KERNEL_SIZE    = 3,
  parameter int CHANNEL_NUM    = 4,
  parameter int RELU_EN        = 1,
  parameter int ACC_WIDTH      = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] kernel_addr,
  input  logic [DATA_WIDTH-1:0] kernel_in,
  output logic                  result_wr_en,
  output logic [ADDR_WIDTH-1:0] result_wr_addr,
  output logic [DATA_WIDTH-1:0] result_wr_data,
  output logic [ADDR_WIDTH-1:0] channel_count,
  output logic                  busy,
  output logic                  done
);

  if (KERNEL_SIZE > IN_WIDTH || KERNEL_SIZE > IN_HEIGHT) begin : g_bad_kernel
    $error("conv_multichannel_engine: KERNEL_SIZE exceeds the input feature map");
  end
  if (ACC_WIDTH < 2 * DATA_WIDTH + $clog2(CHANNEL_NUM * KERNEL_SIZE * KERNEL_SIZE) ||
      ACC_WIDTH < DATA_WIDTH + FRACTION_WIDTH || ACC_WIDTH > SAT_WIDTH) begin : g_bad_acc
    $error("conv_multichannel_engine: ACC_WIDTH out of range");
  end

  state_e                        state_q;
  logic signed [ACC_WIDTH-1:0]   acc_q;
  logic        [DATA_WIDTH-1:0]  bias_q;
  logic                          wr_en_q, busy_q, done_q;
  logic        [ADDR_WIDTH-1:0]  wr_addr_q;
  logic        [DATA_WIDTH-1:0]  wr_data_q;

  logic                          first_tap, last_tap, last_pixel;
  logic                          step_tap, step_pixel, clear_cnt;
  logic        [ADDR_WIDTH-1:0]  out_idx;

  logic signed [2*DATA_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]    product_ext, acc_final, bias_ext, scaled;
  logic signed [SAT_WIDTH-1:0]    scaled_wide, sat_val;
  logic        [DATA_WIDTH-1:0]   result_next;

  assign clear_cnt  = run && (state_q == IDLE || state_q == DONE);
  assign step_tap   = (state_q == FETCH) && !last_tap;
  assign step_pixel = (state_q == OUTPUT);

  conv_addr_gen #(
    .IN_WIDTH   (IN_WIDTH),
    .IN_HEIGHT  (IN_HEIGHT),
    .KERNEL_SIZE(KERNEL_SIZE),
    .CHANNEL_NUM(CHANNEL_NUM),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (clear_cnt),
    .step_tap_i   (step_tap),
    .step_pixel_i (step_pixel),
    .data_addr_o  (data_addr),
    .kernel_addr_o(kernel_addr),
    .channel_o    (channel_count),
    .out_idx_o    (out_idx),
    .first_tap_o  (first_tap),
    .last_tap_o   (last_tap),
    .last_pixel_o (last_pixel)
  );

  // Read data lags the address by one cycle, so each product belongs to the previous tap.
  assign product     = $signed(data_in) * $signed(kernel_in);
  assign product_ext = ACC_WIDTH'(product);
  assign acc_final   = acc_q + product_ext;
  assign bias_ext    = ACC_WIDTH'($signed(bias_q)) <<< FRACTION_WIDTH;
  assign scaled      = (acc_final + bias_ext) >>> FRACTION_WIDTH;
  assign scaled_wide = SAT_WIDTH'(scaled);
  assign sat_val     = sat_relu(scaled_wide, DATA_WIDTH, RELU_EN != 0);
  assign result_next = sat_val[DATA_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      bias_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (run) begin
            state_q <= FETCH;
            bias_q  <= bias;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        FETCH: begin
          acc_q <= first_tap ? '0 : acc_final;
          if (last_tap) state_q <= DRAIN;
        end
        DRAIN: begin
          acc_q     <= acc_final;
          wr_en_q   <= 1'b1;
          wr_addr_q <= out_idx;
          wr_data_q <= result_next;
          state_q   <= OUTPUT;
        end
        OUTPUT: begin
          if (last_pixel) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_wr_en   = wr_en_q;
  assign result_wr_addr = wr_addr_q;
  assign result_wr_data = wr_data_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_conv_multichannel_engine.sv
// Scoreboard bench: two engines (ReLU on / off) share memories; a reference
// convolution model queues expected writes that a monitor pops and compares.
module tb_conv_multichannel_engine;

  localparam int IW   = 12;
  localparam int K    = 3;
  localparam int C    = 4;
  localparam int OW   = 10;
  localparam int OH   = 10;
  localparam int PIX  = OW * OH;
  localparam int DONE_CYCLE = PIX * (C * K * K + 2) + 1;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] biasIn;

  logic [15:0] dataAddr     [2];
  logic [15:0] dataIn       [2];
  logic [15:0] kernelAddr   [2];
  logic [15:0] kernelIn     [2];
  logic        wrEn         [2];
  logic [15:0] wrAddr       [2];
  logic [15:0] wrData       [2];
  logic [15:0] channelCount [2];
  logic        busy         [2];
  logic        done         [2];

  logic signed [15:0] dmem [C*IW*IW];
  logic signed [15:0] wmem [C*K*K];

  exp_t expQ0[$];
  exp_t expQ1[$];

  int checks;
  int failures;
  int cycleNow;
  int runEdge;
  int wrCount  [2];
  int lastWr   [2];
  int startCnt [2];

  // Instance 0 has ReLU enabled, instance 1 passes negative results through.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    conv_multichannel_engine #(.RELU_EN(g == 0 ? 1 : 0)) dut (
      .clk           (clk),
      .reset         (reset),
      .run           (run),
      .bias          (biasIn),
      .data_addr     (dataAddr[g]),
      .data_in       (dataIn[g]),
      .kernel_addr   (kernelAddr[g]),
      .kernel_in     (kernelIn[g]),
      .result_wr_en  (wrEn[g]),
      .result_wr_addr(wrAddr[g]),
      .result_wr_data(wrData[g]),
      .channel_count (channelCount[g]),
      .busy          (busy[g]),
      .done          (done[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cycleNow++;
    for (int g = 0; g < 2; g++) begin
      dataIn[g]   <= dmem[dataAddr[g]];
      kernelIn[g] <= wmem[kernelAddr[g]];
    end
  end

  task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] refPixel(input int r, input int c,
                                           input logic signed [15:0] b, input bit relu);
    longint acc;
    longint s;
    acc = 0;
    for (int ch = 0; ch < C; ch++)
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          acc += longint'(dmem[ch*IW*IW + (r+kr)*IW + (c+kc)]) * longint'(wmem[ch*K*K + kr*K + kc]);
    s = (acc + longint'(b) * 256) >>> 8;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return 16'(s);
  endfunction

  task automatic checkOutput(input int g, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    int   sz;
    sz = (g == 0) ? expQ0.size() : expQ1.size();
    if (sz == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpectedWrite[%0d]: actual addr=%0h data=%0h expected no write", g, a, d);
    end else begin
      if (g == 0) e = expQ0.pop_front();
      else        e = expQ1.pop_front();
      checkEq($sformatf("wrAddr[%0d]", g), a, e.addr);
      checkEq($sformatf("wrData[%0d] px%0d", g, e.addr), d, e.data);
    end
  endtask

  // Monitor: every presented write is matched against the head of the scoreboard.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (wrEn[g] === 1'b1) begin
        wrCount[g]++;
        lastWr[g] = cycleNow - runEdge + 1;
        checkOutput(g, wrAddr[g], wrData[g]);
      end
    end
  end

  task automatic fillConst(input logic [15:0] d, input logic [15:0] w);
    foreach (dmem[i]) dmem[i] = d;
    foreach (wmem[i]) wmem[i] = w;
  endtask

  task automatic fillRandom(input int span);
    int v;
    foreach (dmem[i]) begin
      v = int'($urandom_range(2 * span)) - span;
      dmem[i] = 16'(v);
    end
    foreach (wmem[i]) begin
      v = int'($urandom_range(2 * span)) - span;
      wmem[i] = 16'(v);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] b);
    exp_t e;
    for (int r = 0; r < OH; r++) begin
      for (int c = 0; c < OW; c++) begin
        e.addr = 16'(r * OW + c);
        e.data = refPixel(r, c, b, 1'b1);
        expQ0.push_back(e);
        e.data = refPixel(r, c, b, 1'b0);
        expQ1.push_back(e);
      end
    end
    @(negedge clk);
    run    = 1'b1;
    biasIn = b;
    @(posedge clk);
    #1;
    runEdge     = cycleNow;
    run         = 1'b0;
    startCnt[0] = wrCount[0];
    startCnt[1] = wrCount[1];
  endtask

  task automatic waitDone(input string tag);
    while (!(done[0] === 1'b1 && done[1] === 1'b1) && (cycleNow - runEdge) < 5000) begin
      @(posedge clk);
      #1;
    end
    if (!(done[0] === 1'b1 && done[1] === 1'b1)) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s doneTimeout: actual done=%0b/%0b expected 1 within 5000 cycles",
               tag, done[0], done[1]);
    end else begin
      checkEq({tag, " doneCycle"}, 64'(cycleNow - runEdge + 1), 64'(DONE_CYCLE));
      checkEq({tag, " lastWriteCycle"}, 64'(lastWr[0]), 64'(DONE_CYCLE - 1));
      checkEq({tag, " writes0"}, 64'(wrCount[0] - startCnt[0]), 64'(PIX));
      checkEq({tag, " writes1"}, 64'(wrCount[1] - startCnt[1]), 64'(PIX));
      checkEq({tag, " busyAtDone"}, 64'(busy[0]), 64'd0);
      checkEq({tag, " pending"}, 64'(expQ0.size() + expQ1.size()), 64'd0);
      repeat (2) @(negedge clk);
      checkEq({tag, " doneHeld"}, 64'(done[1]), 64'd1);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    for (int g = 0; g < 2; g++) begin
      checkEq($sformatf("%s dataAddr[%0d]", tag, g), 64'(dataAddr[g]), 64'd0);
      checkEq($sformatf("%s kernelAddr[%0d]", tag, g), 64'(kernelAddr[g]), 64'd0);
      checkEq($sformatf("%s wrEn[%0d]", tag, g), 64'(wrEn[g]), 64'd0);
      checkEq($sformatf("%s wrAddr[%0d]", tag, g), 64'(wrAddr[g]), 64'd0);
      checkEq($sformatf("%s wrData[%0d]", tag, g), 64'(wrData[g]), 64'd0);
      checkEq($sformatf("%s channel[%0d]", tag, g), 64'(channelCount[g]), 64'd0);
      checkEq($sformatf("%s busy[%0d]", tag, g), 64'(busy[g]), 64'd0);
      checkEq($sformatf("%s done[%0d]", tag, g), 64'(done[g]), 64'd0);
    end
  endtask

  // Address trace of the first pixel, then the held addresses during the drain cycle.
  task automatic checkTrace();
    int ch, kr, kc;
    for (int t = 0; t < C * K * K; t++) begin
      @(negedge clk);
      ch = t / (K * K);
      kr = (t % (K * K)) / K;
      kc = t % K;
      checkEq($sformatf("trace kernelAddr t%0d", t), 64'(kernelAddr[0]), 64'(t));
      checkEq($sformatf("trace dataAddr t%0d", t), 64'(dataAddr[0]), 64'(ch*IW*IW + kr*IW + kc));
      checkEq($sformatf("trace channel t%0d", t), 64'(channelCount[0]), 64'(ch));
      checkEq($sformatf("trace busy t%0d", t), 64'(busy[0]), 64'd1);
    end
    @(negedge clk);
    checkEq("drain dataAddr", 64'(dataAddr[0]), 64'((C-1)*IW*IW + (K-1)*IW + (K-1)));
    checkEq("drain kernelAddr", 64'(kernelAddr[0]), 64'(C*K*K - 1));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cycleNow = 0;
    runEdge  = 0;
    reset    = 1'b1;
    run      = 1'b0;
    biasIn   = '0;
    fillConst(16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #2;
    checkIdleOutputs("reset");
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] all ones, address trace");
    fillConst(16'd256, 16'd256);
    applyStimulus(16'h0000);
    checkTrace();
    waitDone("ones");

    $display("[TB] saturation");
    fillConst(16'd25600, 16'd512);
    applyStimulus(16'h0000);
    waitDone("sat");

    $display("[TB] negative weights");
    fillConst(16'd256, 16'hFF00);
    applyStimulus(16'h0000);
    waitDone("neg");

    $display("[TB] bias only");
    fillConst(16'd0, 16'd256);
    applyStimulus(16'h008A);
    waitDone("biasPos");
    applyStimulus(16'hFF76);
    waitDone("biasNeg");

    $display("[TB] random with ignored run while busy");
    fillRandom(400);
    applyStimulus(16'($urandom));
    repeat (200) @(negedge clk);
    run    = 1'b1;
    biasIn = 16'h1234;
    @(negedge clk);
    run = 1'b0;
    waitDone("busyRun");

    $display("[TB] random full range");
    foreach (dmem[i]) dmem[i] = 16'($urandom);
    foreach (wmem[i]) wmem[i] = 16'($urandom);
    applyStimulus(16'($urandom));
    waitDone("fullRange");

    $display("[TB] reset mid-operation");
    fillRandom(300);
    applyStimulus(16'($urandom_range(511)));
    while ((cycleNow - runEdge) < 499) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkIdleOutputs("midReset");
    expQ0.delete();
    expQ1.delete();
    startCnt[0] = wrCount[0];
    startCnt[1] = wrCount[1];
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    checkEq("writesAfterReset0", 64'(wrCount[0] - startCnt[0]), 64'd0);
    checkEq("writesAfterReset1", 64'(wrCount[1] - startCnt[1]), 64'd0);
    checkEq("idleBusyAfterReset", 64'(busy[0]), 64'd0);
    fillRandom(300);
    applyStimulus(16'($urandom_range(511)));
    waitDone("rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_multichannel_engine.md
Name: conv_multichannel_engine

Overview:
Parametrised successor to the two-channel conv-2 wrapper. It sequences a stride-1, valid-padding KxK convolution over CHANNEL_NUM input channels and accumulates across all channels in one wide accumulator. It adds a per-layer bias, shifts back to fixed point, saturates, optionally applies ReLU, and writes one result per output pixel to an external result buffer. It sits between the feature-map/weight M10K memories and the next layer's input buffer. A single flattened weight address space replaces the per-channel weight-memory mux.

Parameters:
DATA_WIDTH, 16, signed fixed-point word width of data, weight, bias and result
FRACTION_WIDTH, 8, fractional bits (1.0 = 2^FRACTION_WIDTH)
ADDR_WIDTH, 16, width of all address ports
IN_WIDTH, 12, input feature-map width
IN_HEIGHT, 12, input feature-map height
KERNEL_SIZE, 3, kernel edge K
CHANNEL_NUM, 4, input channels C (>=1)
RELU_EN, 1, 1 = clamp negative results to 0
ACC_WIDTH, 40, accumulator width (must be >= 2*DATA_WIDTH + clog2(C*K*K))

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high; forces IDLE
run  in  1  start pulse; sampled only in IDLE/DONE
bias  in  DATA_WIDTH  signed layer bias, sampled with run
data_addr  out  ADDR_WIDTH  feature-map read address
data_in  in  DATA_WIDTH  feature-map read data, 1-cycle read latency
kernel_addr  out  ADDR_WIDTH  weight read address
kernel_in  in  DATA_WIDTH  weight read data, 1-cycle read latency
result_wr_en  out  1  one-cycle write strobe
result_wr_addr  out  ADDR_WIDTH  row-major output index
result_wr_data  out  DATA_WIDTH  result word
channel_count  out  ADDR_WIDTH  channel currently being fetched
busy  out  1  high from the cycle after run until done rises
done  out  1  high and held after the last write; cleared by the next accepted run or by reset

Behaviour:
- Derived sizes: OUT_W = IN_WIDTH-K+1 and OUT_H = IN_HEIGHT-K+1. Elaboration error if K > IN_WIDTH or K > IN_HEIGHT.
- Reset (asynchronous): state IDLE; all outputs 0; accumulator, counters and latched bias cleared.
- States:
  - IDLE -> FETCH on run; bias is latched. DONE -> FETCH on run; done drops.
  - FETCH lasts C*K*K cycles. Loop order is channel (outer), kernel row, kernel column (inner).
  - data_addr = c*IN_WIDTH*IN_HEIGHT + (row+kr)*IN_WIDTH + (col+kc).
  - kernel_addr = c*K*K + kr*K + kc.
  - Each cycle accumulates the signed product data_in*kernel_in of the address issued on the previous cycle. The accumulator is cleared on the first FETCH cycle of each pixel.
  - DRAIN: 1 cycle; accumulates the last product. No address is issued; address outputs hold their last values.
  - OUTPUT: 1 cycle.
    - s = (acc + sign-extended bias<<FRACTION_WIDTH) >>> FRACTION_WIDTH (arithmetic shift, floor).
    - Saturate s to [-2^(DW-1), 2^(DW-1)-1]. If RELU_EN, negative results become 0.
    - result_wr_en=1, result_wr_addr = row*OUT_W + col.
    - Advance col; wrap to 0 and increment row. After pixel (OUT_H-1, OUT_W-1) go to DONE, otherwise go to FETCH.
  - DONE: done=1, busy=0.
- Per-pixel cost is C*K*K+2 cycles. The first FETCH cycle is the cycle after run is sampled. The last write occurs at cycle OUT_W*OUT_H*(C*K*K+2), counting run's edge as cycle 0. done rises on the next cycle.
- run while busy: ignored; bias is not re-latched.
- Reset mid-operation: immediate abort. No further writes; the next run restarts from pixel 0.
- result_wr_en is 0 in every state except OUTPUT.

Decomposition:
- Package conv_engine_pkg:
  - state enum: IDLE, FETCH, DRAIN, OUTPUT, DONE.
  - saturate/ReLU function parametrised by widths.
  - clog2-derived width constants.
- One natural sub-module: conv_addr_gen. It holds the channel/kr/kc/row/col counters and the two address computations, with a step input and last_tap/last_pixel outputs.
- The FSM, MAC and output stage stay in the top module.

Test Plan:
All tests use default parameters (OUT 10x10, 38 cycles/pixel), and 1.0 = 256.
- All data 256, all weights 256, bias 0 -> 100 writes, every result 0x2400 (36.0). Addresses 0..99 in order. done rises at cycle 3801.
- Address trace, first pixel -> kernel_addr 0..35 in order. data_addr 0,1,2,12,13,14,24,25,26, then 144,145,146,... for channel 1. channel_count steps 0,1,2,3 every 9 cycles.
- Data 25600 (100.0), weights 512 (2.0) -> every result saturates to 0x7FFF.
- Data 256, weights 0xFF00 (-1.0), bias 0. RELU_EN=1 -> all results 0x0000. RELU_EN=0 -> all results 0xDC00.
- Data 0, bias 0x008A -> every result 0x008A. Bias 0xFF76 with RELU_EN=0 -> 0xFF76.
- Assert reset at cycle 500 -> all outputs 0 in the same cycle and no further writes. A re-issued run completes 100 writes. A run pulse during busy changes neither timing nor results.
